// File: rtl/eth_rx_pkg.sv
// Shared types and sizing helpers for the Ethernet receive frame writer.
package eth_rx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DROP = 2'd2
    } state_t;

    // Byte-length width: one extra bit so a completely full slot is representable.
    function automatic int len_width(input int ram_size, input int nslot_bits, input int byte_width);
        return ram_size - nslot_bits + $clog2(byte_width) + 1;
    endfunction

    function automatic int slot_words(input int ram_size, input int nslot_bits);
        return 2 ** (ram_size - nslot_bits);
    endfunction

endpackage

// File: rtl/eth_rx_slot_ring.sv
// Ring of frame slots: write/read slot pointers, occupancy and per-slot byte lengths.
module eth_rx_slot_ring
    import eth_rx_pkg::*;
#(
    parameter int NSLOT_BITS = 2,
    parameter int LEN_W      = 12
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  commit,
    input  logic [LEN_W-1:0]      commit_len,
    input  logic                  frm_ready,
    output logic [NSLOT_BITS-1:0] wr_slot,
    output logic                  full,
    output logic                  frm_valid,
    output logic [NSLOT_BITS-1:0] frm_slot,
    output logic [LEN_W-1:0]      frm_len
);

    localparam logic [NSLOT_BITS:0] NSLOT = (NSLOT_BITS+1)'(2 ** NSLOT_BITS);

    logic [NSLOT_BITS-1:0] rd_slot;
    logic [NSLOT_BITS:0]   occ_alloc;
    logic [NSLOT_BITS:0]   occ_vis;
    logic                  commit_q;
    logic [LEN_W-1:0]      len_reg [2**NSLOT_BITS];
    logic                  pop;

    // occ_alloc reserves the slot as soon as the last byte arrives so a back-to-back
    // frame sees it as taken; occ_vis publishes it one cycle later, after the RAM write.
    assign pop       = frm_valid && frm_ready;
    assign full      = (occ_alloc == NSLOT);
    assign frm_valid = (occ_vis != '0);
    assign frm_slot  = rd_slot;
    assign frm_len   = len_reg[rd_slot];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_slot   <= '0;
            rd_slot   <= '0;
            occ_alloc <= '0;
            occ_vis   <= '0;
            commit_q  <= 1'b0;
            for (int i = 0; i < 2**NSLOT_BITS; i++) begin
                len_reg[i] <= '0;
            end
        end else begin
            commit_q <= commit;
            if (commit) begin
                len_reg[wr_slot] <= commit_len;
                wr_slot          <= wr_slot + 1'b1;
            end
            if (pop) begin
                rd_slot <= rd_slot + 1'b1;
            end
            case ({commit, pop})
                2'b10:   occ_alloc <= occ_alloc + 1'b1;
                2'b01:   occ_alloc <= occ_alloc - 1'b1;
                default: occ_alloc <= occ_alloc;
            endcase
            case ({commit_q, pop})
                2'b10:   occ_vis <= occ_vis + 1'b1;
                2'b01:   occ_vis <= occ_vis - 1'b1;
                default: occ_vis <= occ_vis;
            endcase
        end
    end

endmodule

// File: rtl/eth_rx_frame_writer.sv
// Packs received bytes into RAM words and commits good frames to a slot ring.
// Optional frame statistics counters are enabled with the ETH_RX_STATS_EN macro.
module eth_rx_frame_writer
    import eth_rx_pkg::*;
#(
    parameter int  RAM_SIZE   = 10,
    parameter int  BYTE_WIDTH = 8,
    parameter int  NSLOT_BITS = 2,
    localparam int LEN_W      = len_width(RAM_SIZE, NSLOT_BITS, BYTE_WIDTH)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [7:0]              rx_byte,
    input  logic                    rx_valid,
    input  logic                    rx_last,
    input  logic                    rx_err,
    output logic                    ram_en,
    output logic [BYTE_WIDTH-1:0]   ram_we,
    output logic [RAM_SIZE-1:0]     ram_addr,
    output logic [BYTE_WIDTH*8-1:0] ram_wrdata,
    output logic                    frm_valid,
    output logic [NSLOT_BITS-1:0]   frm_slot,
    output logic [LEN_W-1:0]        frm_len,
    input  logic                    frm_ready,
    output logic [15:0]             drop_cnt,
    output logic [15:0]             err_cnt
);

    localparam int LANE_W = $clog2(BYTE_WIDTH);
    localparam int WIDX_W = $clog2(slot_words(RAM_SIZE, NSLOT_BITS));

    state_t                  state;
    logic [LEN_W-1:0]        byte_cnt;
    logic [BYTE_WIDTH*8-1:0] hold;
    logic [NSLOT_BITS-1:0]   wr_slot;
    logic                    full;

    logic [LANE_W-1:0]       lane;
    logic [WIDX_W-1:0]       word_idx;
    logic                    at_limit;
    logic [BYTE_WIDTH*8-1:0] next_word;
    logic [BYTE_WIDTH-1:0]   we_mask;
    logic                    accept;
    logic                    do_write;
    logic                    commit;
    logic [LEN_W-1:0]        new_len;

    // byte_cnt only reaches its MSB when the slot is exactly full, so any further byte overflows.
    always_comb begin
        lane      = byte_cnt[LANE_W-1:0];
        word_idx  = byte_cnt[LANE_W +: WIDX_W];
        at_limit  = byte_cnt[LEN_W-1];
        new_len   = byte_cnt + LEN_W'(1);
        next_word = hold;
        we_mask   = '0;
        for (int i = 0; i < BYTE_WIDTH; i++) begin
            if (lane == i[LANE_W-1:0]) begin
                next_word[i*8 +: 8] = rx_byte;
            end
            we_mask[i] = (i[LANE_W-1:0] <= lane);
        end
        accept   = rx_valid && ((state == IDLE && !full) || (state == FILL && !at_limit));
        do_write = accept && (lane == LANE_W'(BYTE_WIDTH-1) || rx_last);
        commit   = accept && rx_last && !rx_err;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            byte_cnt   <= '0;
            hold       <= '0;
            ram_en     <= 1'b0;
            ram_we     <= '0;
            ram_addr   <= '0;
            ram_wrdata <= '0;
        end else begin
            ram_en <= 1'b0;
            ram_we <= '0;
            if (do_write) begin
                ram_en     <= 1'b1;
                ram_we     <= we_mask;
                ram_addr   <= {wr_slot, word_idx};
                ram_wrdata <= next_word;
            end
            if (accept) begin
                hold <= next_word;
            end
            case (state)
                IDLE: begin
                    if (rx_valid) begin
                        if (full) begin
                            state <= rx_last ? IDLE : DROP;
                        end else begin
                            state    <= rx_last ? IDLE : FILL;
                            byte_cnt <= rx_last ? '0 : new_len;
                        end
                    end
                end
                FILL: begin
                    if (rx_valid) begin
                        if (at_limit) begin
                            state    <= rx_last ? IDLE : DROP;
                            byte_cnt <= '0;
                        end else if (rx_last) begin
                            state    <= IDLE;
                            byte_cnt <= '0;
                        end else begin
                            byte_cnt <= new_len;
                        end
                    end
                end
                DROP: begin
                    if (rx_valid && rx_last) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    eth_rx_slot_ring #(
        .NSLOT_BITS (NSLOT_BITS),
        .LEN_W      (LEN_W)
    ) u_ring (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .commit     (commit),
        .commit_len (new_len),
        .frm_ready  (frm_ready),
        .wr_slot    (wr_slot),
        .full       (full),
        .frm_valid  (frm_valid),
        .frm_slot   (frm_slot),
        .frm_len    (frm_len)
    );

`ifdef ETH_RX_STATS_EN
    logic start_drop;
    logic overflow;
    logic err_end;

    assign start_drop = rx_valid && (state == IDLE) && full;
    assign overflow   = rx_valid && (state == FILL) && at_limit;
    assign err_end    = accept && rx_last && rx_err;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            drop_cnt <= '0;
            err_cnt  <= '0;
        end else begin
            if ((start_drop || overflow) && drop_cnt != 16'hFFFF) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
            if (err_end && err_cnt != 16'hFFFF) begin
                err_cnt <= err_cnt + 16'd1;
            end
        end
    end
`else
    assign drop_cnt = '0;
    assign err_cnt  = '0;
`endif

endmodule

// File: tb/tb_eth_rx_frame_writer.sv
// Self-checking bench for eth_rx_frame_writer against a frame-level reference model.
module tb_eth_rx_frame_writer;

    localparam int RAM_SIZE   = 10;
    localparam int BYTE_WIDTH = 8;
    localparam int NSLOT_BITS = 2;
    localparam int LEN_W      = 12;
    localparam int NSLOT      = 4;
    localparam int SLOT_WORDS = 256;
    localparam int SLOT_BYTES = 2048;
    localparam int WR_W       = RAM_SIZE + BYTE_WIDTH + BYTE_WIDTH*8;
    localparam int DESC_W     = NSLOT_BITS + LEN_W;
`ifdef ETH_RX_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    // clock / reset
    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    logic [7:0]              rx_byte   = '0;
    logic                    rx_valid  = 1'b0;
    logic                    rx_last   = 1'b0;
    logic                    rx_err    = 1'b0;
    logic                    frm_ready = 1'b0;
    logic                    ram_en;
    logic [BYTE_WIDTH-1:0]   ram_we;
    logic [RAM_SIZE-1:0]     ram_addr;
    logic [BYTE_WIDTH*8-1:0] ram_wrdata;
    logic                    frm_valid;
    logic [NSLOT_BITS-1:0]   frm_slot;
    logic [LEN_W-1:0]        frm_len;
    logic [15:0]             drop_cnt;
    logic [15:0]             err_cnt;

    eth_rx_frame_writer #(
        .RAM_SIZE   (RAM_SIZE),
        .BYTE_WIDTH (BYTE_WIDTH),
        .NSLOT_BITS (NSLOT_BITS)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .rx_byte    (rx_byte),
        .rx_valid   (rx_valid),
        .rx_last    (rx_last),
        .rx_err     (rx_err),
        .ram_en     (ram_en),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wrdata (ram_wrdata),
        .frm_valid  (frm_valid),
        .frm_slot   (frm_slot),
        .frm_len    (frm_len),
        .frm_ready  (frm_ready),
        .drop_cnt   (drop_cnt),
        .err_cnt    (err_cnt)
    );

    // reference model state
    int n_cmp  = 0;
    int n_fail = 0;
    logic [WR_W-1:0]   exp_q[$];
    logic [DESC_W-1:0] desc_q[$];
    logic [7:0]        frm_bytes [0:2099];
    int m_wr_slot = 0;
    int m_occ     = 0;
    int m_drop    = 0;
    int m_err     = 0;

    // word k of a slot holds frame bytes k*8 .. k*8+7, lane l at bits l*8
    function automatic void push_words(input int slot, input int nw, input int nbytes);
        logic [BYTE_WIDTH-1:0]   we;
        logic [BYTE_WIDTH*8-1:0] d;
        logic [RAM_SIZE-1:0]     a;
        int idx;
        for (int k = 0; k < nw; k++) begin
            we = '0;
            d  = '0;
            for (int l = 0; l < BYTE_WIDTH; l++) begin
                idx = k*BYTE_WIDTH + l;
                if (idx < nbytes) begin
                    we[l]       = 1'b1;
                    d[l*8 +: 8] = frm_bytes[idx];
                end
            end
            a = RAM_SIZE'(slot*SLOT_WORDS + k);
            exp_q.push_back({a, we, d});
        end
    endfunction

    function automatic void model_frame(input int len, input bit err);
        if (m_occ >= NSLOT) begin
            m_drop++;
        end else if (len > SLOT_BYTES) begin
            push_words(m_wr_slot, SLOT_WORDS, SLOT_BYTES);
            m_drop++;
        end else begin
            push_words(m_wr_slot, (len + BYTE_WIDTH - 1) / BYTE_WIDTH, len);
            if (err) begin
                m_err++;
            end else begin
                desc_q.push_back({NSLOT_BITS'(m_wr_slot), LEN_W'(len)});
                m_wr_slot = (m_wr_slot + 1) % NSLOT;
                m_occ++;
            end
        end
    endfunction

    // scoreboard: RAM writes, with unwritten lanes blanked
    logic [BYTE_WIDTH*8-1:0] mon_data;
    logic [WR_W-1:0]         mon_got;
    logic [WR_W-1:0]         mon_exp;
    always @(negedge clk_i) begin
        if (ram_en) begin
            mon_data = ram_wrdata;
            for (int l = 0; l < BYTE_WIDTH; l++) begin
                if (!ram_we[l]) mon_data[l*8 +: 8] = 8'h00;
            end
            mon_got = {ram_addr, ram_we, mon_data};
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL ram_write unexpected: got addr=%0d we=%h data=%h, expected no write",
                         ram_addr, ram_we, mon_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp) begin
                    n_fail++;
                    $display("FAIL ram_write: got addr=%0d we=%h data=%h, expected addr=%0d we=%h data=%h",
                             ram_addr, ram_we, mon_data, mon_exp[WR_W-1 -: RAM_SIZE],
                             mon_exp[BYTE_WIDTH*9-1 -: BYTE_WIDTH], mon_exp[BYTE_WIDTH*8-1:0]);
                end
            end
        end
    end

    // scoreboard: descriptor pops
    logic [DESC_W-1:0] desc_exp;
    always @(negedge clk_i) begin
        if (rst_ni && frm_valid && frm_ready) begin
            n_cmp++;
            if (desc_q.size() == 0) begin
                n_fail++;
                $display("FAIL desc_pop unexpected: got slot=%0d len=%0d, expected none", frm_slot, frm_len);
            end else begin
                desc_exp = desc_q.pop_front();
                m_occ--;
                if ({frm_slot, frm_len} !== desc_exp) begin
                    n_fail++;
                    $display("FAIL desc_pop: got slot=%0d len=%0d, expected slot=%0d len=%0d",
                             frm_slot, frm_len, desc_exp[DESC_W-1 -: NSLOT_BITS], desc_exp[LEN_W-1:0]);
                end
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_i); #1;
            rx_valid = 1'b0;
            rx_last  = 1'b0;
            rx_err   = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst_ni    = 1'b0;
        rx_valid  = 1'b0;
        rx_last   = 1'b0;
        rx_err    = 1'b0;
        frm_ready = 1'b0;
        exp_q.delete();
        desc_q.delete();
        m_wr_slot = 0;
        m_occ     = 0;
        m_drop    = 0;
        m_err     = 0;
        repeat (3) @(posedge clk_i);
        #1 rst_ni = 1'b1;
    endtask

    // returns with the final byte still driven, so consecutive calls are back-to-back
    task automatic send_frame(input int len, input bit err, input bit rnd, input bit gaps);
        for (int i = 0; i < len; i++) begin
            frm_bytes[i] = rnd ? 8'($urandom) : 8'(i);
        end
        model_frame(len, err);
        for (int i = 0; i < len; i++) begin
            if (gaps && i > 0 && $urandom_range(0, 3) == 0) begin
                idle($urandom_range(1, 2));
            end
            @(posedge clk_i); #1;
            rx_valid = 1'b1;
            rx_byte  = frm_bytes[i];
            rx_last  = (i == len - 1);
            rx_err   = err && (i == len - 1);
        end
    endtask

    task automatic pop_one();
        int t;
        t = 0;
        while (!frm_valid && t < 20) begin
            @(posedge clk_i); #1;
            t++;
        end
        if (!frm_valid) begin
            n_cmp++;
            n_fail++;
            $display("FAIL pop_wait: got frm_valid=0 after %0d cycles, expected 1", t);
        end else begin
            frm_ready = 1'b1;
            @(posedge clk_i); #1;
            frm_ready = 1'b0;
        end
    endtask

    // tests
    task automatic test_reset();
        rst_ni = 1'b0;
        #2;
        n_cmp++;
        if ({ram_en, ram_we, ram_addr, ram_wrdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_ram: got en=%b we=%h addr=%0d data=%h, expected all 0", ram_en, ram_we, ram_addr, ram_wrdata);
        end
        n_cmp++;
        if ({frm_valid, frm_slot, frm_len} !== '0) begin
            n_fail++;
            $display("FAIL reset_frm: got valid=%b slot=%0d len=%0d, expected 0", frm_valid, frm_slot, frm_len);
        end
        n_cmp++;
        if ({drop_cnt, err_cnt} !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_cnt: got drop=%0d err=%0d, expected 0", drop_cnt, err_cnt);
        end
        do_reset();
    endtask

    task automatic test_good_frame();
        do_reset();
        send_frame(64, 1'b0, 1'b0, 1'b0);
        idle(1);
        @(negedge clk_i);
        n_cmp++;
        if ({ram_en, ram_addr, frm_valid} !== {1'b1, 10'd7, 1'b0}) begin
            n_fail++;
            $display("FAIL good_last_write: got en=%b addr=%0d frm_valid=%b, expected en=1 addr=7 frm_valid=0", ram_en, ram_addr, frm_valid);
        end
        @(negedge clk_i);
        n_cmp++;
        if ({ram_en, frm_valid, frm_slot, frm_len} !== {1'b0, 1'b1, 2'd0, 12'd64}) begin
            n_fail++;
            $display("FAIL good_commit: got en=%b valid=%b slot=%0d len=%0d, expected en=0 valid=1 slot=0 len=64", ram_en, frm_valid, frm_slot, frm_len);
        end
        idle(3);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL good_writes: got %0d writes missing, expected 0", exp_q.size());
        end
        pop_one();
        n_cmp++;
        if (frm_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL good_popped: got frm_valid=%b, expected 0", frm_valid);
        end
    endtask

    task automatic test_partial();
        do_reset();
        send_frame(61, 1'b0, 1'b1, 1'b1);
        idle(4);
        n_cmp++;
        if (exp_q.size() != 0 || frm_len !== 12'd61) begin
            n_fail++;
            $display("FAIL partial: got missing=%0d frm_len=%0d, expected missing=0 frm_len=61", exp_q.size(), frm_len);
        end
        pop_one();
    endtask

    task automatic test_err();
        do_reset();
        send_frame(30, 1'b1, 1'b1, 1'b0);
        idle(4);
        n_cmp++;
        if (frm_valid !== 1'b0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL err_discard: got frm_valid=%b missing=%0d, expected frm_valid=0 missing=0", frm_valid, exp_q.size());
        end
        frm_ready = 1'b1;
        idle(1);
        frm_ready = 1'b0;
        send_frame(16, 1'b0, 1'b1, 1'b0);
        idle(4);
        n_cmp++;
        if (exp_q.size() != 0 || frm_slot !== 2'd0) begin
            n_fail++;
            $display("FAIL err_reuse: got missing=%0d slot=%0d, expected missing=0 slot=0", exp_q.size(), frm_slot);
        end
        pop_one();
        n_cmp++;
        if (err_cnt !== 16'(STATS_ON ? m_err : 0) || drop_cnt !== 16'(STATS_ON ? m_drop : 0)) begin
            n_fail++;
            $display("FAIL err_counters: got drop=%0d err=%0d, expected drop=%0d err=%0d", drop_cnt, err_cnt,
                     STATS_ON ? m_drop : 0, STATS_ON ? m_err : 0);
        end
    endtask

    task automatic test_full();
        do_reset();
        for (int f = 0; f < 5; f++) begin
            send_frame($urandom_range(1, 40), 1'b0, 1'b1, 1'b0);
        end
        idle(4);
        n_cmp++;
        if (exp_q.size() != 0 || drop_cnt !== 16'(STATS_ON ? m_drop : 0)) begin
            n_fail++;
            $display("FAIL full_drop: got missing=%0d drop=%0d, expected missing=0 drop=%0d", exp_q.size(), drop_cnt, STATS_ON ? m_drop : 0);
        end
        pop_one();
        send_frame(24, 1'b0, 1'b1, 1'b1);
        idle(4);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL full_sixth: got %0d writes missing, expected 0", exp_q.size());
        end
        repeat (4) pop_one();
        n_cmp++;
        if (frm_valid !== 1'b0 || desc_q.size() != 0) begin
            n_fail++;
            $display("FAIL full_drain: got frm_valid=%b left=%0d, expected 0 and 0", frm_valid, desc_q.size());
        end
    endtask

    task automatic test_overflow();
        do_reset();
        send_frame(2049, 1'b0, 1'b1, 1'b0);
        idle(4);
        n_cmp++;
        if (exp_q.size() != 0 || frm_valid !== 1'b0 || drop_cnt !== 16'(STATS_ON ? m_drop : 0)) begin
            n_fail++;
            $display("FAIL overflow: got missing=%0d frm_valid=%b drop=%0d, expected 0 0 %0d", exp_q.size(), frm_valid, drop_cnt, STATS_ON ? m_drop : 0);
        end
        send_frame(2048, 1'b0, 1'b1, 1'b0);
        send_frame(20, 1'b0, 1'b1, 1'b0);
        idle(4);
        n_cmp++;
        if (exp_q.size() != 0 || frm_len !== 12'd2048) begin
            n_fail++;
            $display("FAIL exact_slot: got missing=%0d len=%0d, expected 0 2048", exp_q.size(), frm_len);
        end
        repeat (2) pop_one();
    endtask

    task automatic test_commit_pop();
        do_reset();
        send_frame(10, 1'b0, 1'b1, 1'b0);
        send_frame(17, 1'b0, 1'b1, 1'b0);
        idle(4);
        send_frame(9, 1'b0, 1'b1, 1'b0);
        idle(1);
        frm_ready = 1'b1;
        @(posedge clk_i); #1;
        frm_ready = 1'b0;
        idle(3);
        // two more fit only if occupancy stayed at two; the third must be dropped
        for (int f = 0; f < 3; f++) begin
            send_frame($urandom_range(1, 20), 1'b0, 1'b1, 1'b0);
        end
        idle(4);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL commit_pop_writes: got %0d missing, expected 0", exp_q.size());
        end
        repeat (4) pop_one();
        n_cmp++;
        if (frm_valid !== 1'b0 || desc_q.size() != 0) begin
            n_fail++;
            $display("FAIL commit_pop_drain: got frm_valid=%b left=%0d, expected 0 and 0", frm_valid, desc_q.size());
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        send_frame(3, 1'b0, 1'b1, 1'b0);
        send_frame(1, 1'b0, 1'b1, 1'b0);
        send_frame(9, 1'b1, 1'b1, 1'b0);
        send_frame(8, 1'b0, 1'b1, 1'b1);
        send_frame(1, 1'b0, 1'b1, 1'b0);
        send_frame(2, 1'b0, 1'b1, 1'b0);
        idle(4);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_writes: got %0d missing, expected 0", exp_q.size());
        end
        while (desc_q.size() > 0) pop_one();
        idle(2);
        n_cmp++;
        if (frm_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_drain: got frm_valid=%b, expected 0", frm_valid);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        send_frame(10, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) frm_bytes[i] = 8'($urandom);
        push_words(1, 2, 16);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk_i); #1;
            rx_valid = 1'b1;
            rx_byte  = frm_bytes[i];
            rx_last  = 1'b0;
        end
        idle(3);
        n_cmp++;
        if (exp_q.size() != 0 || frm_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_prefix: got missing=%0d frm_valid=%b, expected 0 1", exp_q.size(), frm_valid);
        end
        #2 rst_ni = 1'b0;
        #1;
        n_cmp++;
        if ({ram_en, ram_we, ram_addr, ram_wrdata, frm_valid, frm_slot, frm_len, drop_cnt, err_cnt} !== '0) begin
            n_fail++;
            $display("FAIL mid_reset: got addr=%0d valid=%b slot=%0d len=%0d, expected all outputs 0", ram_addr, frm_valid, frm_slot, frm_len);
        end
        desc_q.delete();
        m_wr_slot = 0;
        m_occ     = 0;
        m_drop    = 0;
        m_err     = 0;
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        send_frame(12, 1'b0, 1'b1, 1'b0);
        idle(4);
        n_cmp++;
        if (exp_q.size() != 0 || frm_slot !== 2'd0 || frm_len !== 12'd12) begin
            n_fail++;
            $display("FAIL mid_after: got missing=%0d slot=%0d len=%0d, expected 0 0 12", exp_q.size(), frm_slot, frm_len);
        end
        pop_one();
    endtask

    task automatic test_random();
        do_reset();
        for (int f = 0; f < 40; f++) begin
            send_frame($urandom_range(1, 80), ($urandom_range(0, 7) == 0), 1'b1, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 3));
            if (m_occ > 0 && $urandom_range(0, 1) == 1) begin
                idle(3);
                pop_one();
            end
        end
        idle(4);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL random_writes: got %0d missing, expected 0", exp_q.size());
        end
        while (desc_q.size() > 0 && frm_valid) pop_one();
        n_cmp++;
        if (frm_valid !== 1'b0 || desc_q.size() != 0) begin
            n_fail++;
            $display("FAIL random_drain: got frm_valid=%b left=%0d, expected 0 and 0", frm_valid, desc_q.size());
        end
        n_cmp++;
        if (drop_cnt !== 16'(STATS_ON ? m_drop : 0) || err_cnt !== 16'(STATS_ON ? m_err : 0)) begin
            n_fail++;
            $display("FAIL random_counters: got drop=%0d err=%0d, expected drop=%0d err=%0d", drop_cnt, err_cnt,
                     STATS_ON ? m_drop : 0, STATS_ON ? m_err : 0);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_partial();
        test_err();
        test_full();
        test_overflow();
        test_commit_pop();
        test_back_to_back();
        test_reset_mid();
        test_random();
        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
